// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver feeding a show-ahead receive FIFO.
// Raw ps2_clk/ps2_data are synchronised, framed into checked bytes, guarded by
// an inter-edge watchdog, and buffered for a ready/nextdata_n pop handshake.
module ps2_rx_fifo #(
  parameter int DEPTH       = 8,
  parameter int TIMEOUT_CYC = 25000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       nextdata_n,
  output logic [7:0] data,
  output logic       ready,
  output logic       overflow,
  output logic       frame_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [TW-1:0] WD_LAST = TW'(TIMEOUT_CYC - 1);

  // Start bit low, odd parity over data+parity, stop bit high.
  function automatic logic frame_ok(input logic [9:0] sh, input logic stop_bit);
    return (sh[0] == 1'b0) && (^sh[9:1] == 1'b1) && (stop_bit == 1'b1);
  endfunction

  logic clk_s0, clk_s1, clk_s2;
  logic data_s0, data_s1, data_s2;

  logic [3:0]    bitcnt;
  logic [9:0]    shreg;
  logic [TW-1:0] wd_cnt;

  logic [AW:0]   wr_ptr, rd_ptr;
  logic [7:0]    mem [DEPTH];

  logic fall, frame_done, frame_good, timeout, frame_bad;
  logic empty, full, pop, push;

  // Synchroniser: identical 3-flop chains keep clock and data aligned.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      clk_s0  <= 1'b0;
      clk_s1  <= 1'b0;
      clk_s2  <= 1'b0;
      data_s0 <= 1'b0;
      data_s1 <= 1'b0;
      data_s2 <= 1'b0;
    end else begin
      clk_s0  <= ps2_clk;
      clk_s1  <= clk_s0;
      clk_s2  <= clk_s1;
      data_s0 <= ps2_data;
      data_s1 <= data_s0;
      data_s2 <= data_s1;
    end
  end

  // data_s2 completes the matched chain but the bit is taken one stage early.
  logic unused_data_s2;
  assign unused_data_s2 = data_s2;

  assign fall       = clk_s2 & ~clk_s1;
  assign frame_done = fall && (bitcnt == 4'd10);
  assign frame_good = frame_done && frame_ok(shreg, data_s1);
  // A real edge always wins over an expiring watchdog in the same cycle.
  assign timeout    = !fall && (bitcnt != 4'd0) && (wd_cnt == WD_LAST);
  assign frame_bad  = (frame_done && !frame_good) || timeout;

  // Frame receiver: shift one bit per falling edge, wrap after the stop bit.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      bitcnt <= 4'd0;
      shreg  <= 10'd0;
    end else if (fall) begin
      shreg  <= {data_s1, shreg[9:1]};
      bitcnt <= (bitcnt == 4'd10) ? 4'd0 : bitcnt + 4'd1;
    end else if (timeout) begin
      bitcnt <= 4'd0;
    end
  end

  // Watchdog: counts idle cycles between edges while a frame is open.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wd_cnt <= '0;
    end else if (fall || bitcnt == 4'd0) begin
      wd_cnt <= '0;
    end else if (wd_cnt != WD_LAST) begin
      wd_cnt <= wd_cnt + TW'(1);
    end
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign ready = ~empty;
  assign pop   = ~nextdata_n & ready;
  // A pop in the same cycle frees the slot the push needs.
  assign push  = frame_good && (!full || pop);

  // FIFO pointers, sticky overflow and the frame error pulse.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (frame_good && !push) overflow <= 1'b1;
      frame_err <= frame_bad;
    end
  end

  // Storage array; contents need no reset since pointers gate visibility.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= shreg[8:1];
  end

  assign data = ready ? mem[rd_ptr[AW-1:0]] : 8'h00;

endmodule
